edabk_transmitter_datapath: RTL and testbench

//  - Datapath and bit timer of the UART transmitter; sits directly downstream of the transmitter controller.
//  - Consumes the controller's load/shift/clear strobes and produces the serial tx line.
//  - Returns the per-bit done strobe to the controller.
//  - Frame: start(0), DATA_WIDTH data bits LSB-first, optional parity bit, stop(1).

---
 rtl/edabk_transmitter_datapath.sv | 104 ++++++++++
 tb/tb_edabk_transmitter_datapath.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/edabk_transmitter_datapath.sv
// ----------------------------------------------------------------------------
// edabk_transmitter_datapath
//
// UART transmitter datapath and bit timer. It takes the load/shift/clear
// strobes from the transmitter controller, serialises a frame onto tx and
// returns a one-cycle done strobe in the last bclk of every bit period.
//
// Frame on the line: start(0), DATA_WIDTH data bits LSB-first, an optional
// parity bit, then stop(1).
//
// Ports
//   bclk        in   baud clock
//   reset_n     in   asynchronous reset, active-low
//   tx_data     in   DATA_WIDTH data word, sampled on load
//   parity      in   1: frame carries a parity bit
//   parity_odd  in   1: odd parity, 0: even parity (sampled on load)
//   load        in   load a new frame and start the bit timer
//   shift       in   advance to the next frame bit
//   clear       in   abort / go idle: line high, timer stopped
//   tx          out  serial line, driven straight from a flop
//   done        out  high in the last bclk of the current bit period
//   busy        out  frame loaded and bit timer running
// ----------------------------------------------------------------------------
`ifndef CFG_CLK_DIV
`define CFG_CLK_DIV 16
`endif
`ifndef CFG_DATA_WIDTH
`define CFG_DATA_WIDTH 8
`endif

module edabk_transmitter_datapath #(
    parameter int CLK_DIV    = `CFG_CLK_DIV,
    parameter int DATA_WIDTH = `CFG_DATA_WIDTH,
    parameter int DIV_WIDTH  = $clog2(CLK_DIV),
    parameter int SREG_WIDTH = DATA_WIDTH + 3
) (
    input  logic                  bclk,
    input  logic                  reset_n,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  parity,
    input  logic                  parity_odd,
    input  logic                  load,
    input  logic                  shift,
    input  logic                  clear,
    output logic                  tx,
    output logic                  done,
    output logic                  busy
);

    localparam logic [DIV_WIDTH-1:0] CNT_MAX = DIV_WIDTH'(CLK_DIV - 1);

    logic [SREG_WIDTH-1:0] sreg_q, sreg_d;
    logic [DIV_WIDTH-1:0]  bit_cnt_q, bit_cnt_d;
    logic                  active_q, active_d;
    logic                  par_bit;

    assign par_bit = (^tx_data) ^ parity_odd;

    always_comb begin
        sreg_d    = sreg_q;
        bit_cnt_d = bit_cnt_q;
        active_d  = active_q;

        // Free-running bit timer; wraps so done keeps repeating if the
        // controller never shifts.
        if (active_q) begin
            bit_cnt_d = (bit_cnt_q == CNT_MAX) ? '0 : bit_cnt_q + 1'b1;
        end

        if (clear) begin
            sreg_d    = '1;
            bit_cnt_d = '0;
            active_d  = 1'b0;
        end else if (load) begin
            // Unused parity slot is filled with 1 so the frame simply has a
            // second stop-level bit at the top that is never reached.
            sreg_d    = parity ? {1'b1, par_bit, tx_data, 1'b0}
                               : {2'b11, tx_data, 1'b0};
            bit_cnt_d = '0;
            active_d  = 1'b1;
        end else if (shift) begin
            // Shifting in 1s keeps the line at idle level past the stop bit.
            sreg_d    = {1'b1, sreg_q[SREG_WIDTH-1:1]};
            bit_cnt_d = '0;
        end
    end

    always_ff @(posedge bclk or negedge reset_n) begin
        if (!reset_n) begin
            sreg_q    <= '1;
            bit_cnt_q <= '0;
            active_q  <= 1'b0;
        end else begin
            sreg_q    <= sreg_d;
            bit_cnt_q <= bit_cnt_d;
            active_q  <= active_d;
        end
    end

    assign tx   = sreg_q[0];
    assign done = active_q && (bit_cnt_q == CNT_MAX);
    assign busy = active_q;

endmodule

// File: tb/tb_edabk_transmitter_datapath.sv
`timescale 1ns/1ps
module tb_edabk_transmitter_datapath;

    localparam int CLK_DIV = 16;
    localparam int DW      = 8;

    logic          bclk = 1'b0;
    logic          reset_n;
    logic [DW-1:0] tx_data;
    logic          parity, parity_odd, load, shift, clear;
    logic          tx, done, busy;

    int total = 0;
    int bad   = 0;
    logic exp_q[$];

    always #5 bclk = ~bclk;

    edabk_transmitter_datapath #(.CLK_DIV(CLK_DIV), .DATA_WIDTH(DW)) dut (
        .bclk(bclk), .reset_n(reset_n), .tx_data(tx_data), .parity(parity),
        .parity_odd(parity_odd), .load(load), .shift(shift), .clear(clear),
        .tx(tx), .done(done), .busy(busy)
    );

    task automatic check(input string tag, input logic obs, input logic expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b t=%0t", tag, obs, expv, $time);
        end
    endtask

    // Expected line bits of one frame, pushed when the load is driven.
    task automatic push_frame(input logic [DW-1:0] d, input logic p, input logic odd);
        exp_q.push_back(1'b0);
        for (int i = 0; i < DW; i++) exp_q.push_back(d[i]);
        if (p) exp_q.push_back((^d) ^ odd);
        exp_q.push_back(1'b1);
    endtask

    // Drive load for one edge; returns at the negedge of the start bit's first cycle.
    task automatic do_load(input logic [DW-1:0] d, input logic p, input logic odd);
        @(negedge bclk);
        tx_data = d; parity = p; parity_odd = odd; load = 1'b1;
        push_frame(d, p, odd);
        $display("load data=%h parity=%b odd=%b", d, p, odd);
        @(negedge bclk);
        load = 1'b0;
    endtask

    // Behaves like the controller: shift in the same cycle done is seen.
    // Every bit must hold for CLK_DIV cycles with done only in the last one.
    task automatic run_bits(input int nbits);
        logic e;
        for (int b = 0; b < nbits; b++) begin
            e = exp_q.pop_front();
            for (int c = 0; c < CLK_DIV; c++) begin
                shift = 1'b0;
                check("tx_bit", tx, e);
                check("done_timing", done, c == CLK_DIV - 1);
                check("busy_frame", busy, 1'b1);
                if (c == CLK_DIV - 1) shift = done;
                @(negedge bclk);
            end
            $display("bit %0d tx=%b expected=%b", b, tx, e);
        end
        shift = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; tx_data = '0; parity = 0; parity_odd = 0;
        load = 0; shift = 0; clear = 0;
        #12;
        check("rst_tx", tx, 1'b1);
        check("rst_done", done, 1'b0);
        check("rst_busy", busy, 1'b0);
        @(negedge bclk); reset_n = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge bclk);
            check("idle_done", done, 1'b0);
            check("idle_tx", tx, 1'b1);
        end
        $display("reset idle 100 cycles checked");

        // A5, no parity, plus shifting past stop keeps the line high.
        do_load(8'hA5, 1'b0, 1'b0);
        run_bits(10);
        check("post_stop_tx", tx, 1'b1);
        // No further shifts: done keeps firing every CLK_DIV cycles, tx holds.
        for (int c = 0; c < 2 * CLK_DIV; c++) begin
            check("repeat_done", done, (c % CLK_DIV) == CLK_DIV - 1);
            check("repeat_tx", tx, 1'b1);
            @(negedge bclk);
        end
        $display("done repeat without shift checked");

        // Parity frames.
        do_load(8'h07, 1'b1, 1'b0);
        run_bits(11);
        do_load(8'h07, 1'b1, 1'b1);
        run_bits(11);

        // Clear on cycle 5 of data bit 3.
        do_load(8'hA5, 1'b0, 1'b0);
        run_bits(4);
        for (int c = 0; c < 5; c++) begin
            check("pre_clear_tx", tx, exp_q[0]);
            @(negedge bclk);
        end
        clear = 1'b1;
        @(negedge bclk);
        clear = 1'b0;
        exp_q.delete();
        check("clear_tx", tx, 1'b1);
        check("clear_busy", busy, 1'b0);
        for (int c = 0; c < 3 * CLK_DIV; c++) begin
            check("clear_no_done", done, 1'b0);
            check("clear_tx_hold", tx, 1'b1);
            @(negedge bclk);
        end
        $display("clear mid-bit checked");

        // load and clear together: clear wins.
        tx_data = 8'h00; load = 1'b1; clear = 1'b1;
        @(negedge bclk);
        load = 1'b0; clear = 1'b0;
        check("ldclr_tx", tx, 1'b1);
        check("ldclr_busy", busy, 1'b0);
        $display("load+clear priority checked");
        do_load(8'hFF, 1'b0, 1'b0);
        run_bits(10);

        // Async reset mid-frame.
        do_load(8'h96, 1'b0, 1'b0);
        run_bits(3);
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_tx", tx, 1'b1);
        check("async_rst_busy", busy, 1'b0);
        exp_q.delete();
        for (int c = 0; c < 20; c++) begin
            @(negedge bclk);
            check("rst_no_done", done, 1'b0);
        end
        reset_n = 1'b1;
        $display("async reset mid-frame checked");
        do_load(8'h3C, 1'b0, 1'b0);
        run_bits(10);
        check("final_tx", tx, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
